// File: rtl/mlp_argmax_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_argmax_pkg
// Description : Shared constants and types for the MLP output-layer argmax
//               stage and its helper blocks.
//               - DATA_WIDTH_DEF  : score word width (codebase dataWidth)
//               - NUM_CLASSES_DEF : score beats per inference
//               - IDX_WIDTH_DEF   : class-index width, clog2(NUM_CLASSES_DEF)
//               - state_e         : 2-bit argmax sequencer state encoding
// Revision    : 1.0  initial release
// ============================================================================
package mlp_argmax_pkg;

  localparam int DATA_WIDTH_DEF  = 16;
  localparam int NUM_CLASSES_DEF = 10;
  localparam int IDX_WIDTH_DEF   = $clog2(NUM_CLASSES_DEF);

  localparam logic [1:0] ST_IDLE_ENC = 2'd0;
  localparam logic [1:0] ST_SCAN_ENC = 2'd1;
  localparam logic [1:0] ST_DONE_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_SCAN = ST_SCAN_ENC,
    ST_DONE = ST_DONE_ENC
  } state_e;

endpackage : mlp_argmax_pkg
`default_nettype wire

// File: rtl/mlp_signed_max_cmp.sv
`default_nettype none
// ============================================================================
// Module      : mlp_signed_max_cmp
// Description : Combinational signed greater-than comparator, shared by the
//               argmax stage and later pooling / top-k blocks.
// Ports       : a  (in,  WIDTH) signed candidate value
//               b  (in,  WIDTH) signed reference value
//               gt (out, 1)     a > b, two's-complement compare
// Revision    : 1.0  initial release
// ============================================================================
module mlp_signed_max_cmp
  import mlp_argmax_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH_DEF
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic                    gt
);

  // Strictly greater: equal values report 0 so the earlier index is kept.
  assign gt = (a > b);

endmodule : mlp_signed_max_cmp
`default_nettype wire

// File: rtl/mlp_argmax.sv
`default_nettype none
// ============================================================================
// Module      : mlp_argmax
// Description : Consumes the serial stream of NUM_CLASSES signed class scores
//               from the last MLP layer, tracks the running maximum and
//               reports the winning class index and score, raising a level
//               interrupt for the host when the result is ready.
// Ports       : s_axi_aclk  (in)  clock
//               reset       (in)  asynchronous active-high reset
//               soft_clear  (in)  synchronous abort back to IDLE
//               in_data     (in)  signed score beat
//               in_valid    (in)  score beat valid
//               in_last     (in)  producer end-of-stream marker
//               in_ready    (out) block can accept a beat
//               out_idx     (out) index of the maximum score
//               out_max     (out) maximum score value
//               out_valid   (out) result valid, held until accepted
//               out_ready   (in)  consumer accepts the result
//               len_err     (out) sticky in_last position mismatch
//               intr        (out) level interrupt on result completion
//               intr_clr    (in)  single-cycle interrupt clear
// Revision    : 1.0  initial release
// ============================================================================
module mlp_argmax
  import mlp_argmax_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int NUM_CLASSES = NUM_CLASSES_DEF,
  parameter int IDX_WIDTH   = IDX_WIDTH_DEF
) (
  input  logic                  s_axi_aclk,
  input  logic                  reset,
  input  logic                  soft_clear,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  len_err,
  output logic                  intr,
  input  logic                  intr_clr
);

  // One spare bit so the final-beat count never wraps for legal parameters.
  localparam int                   CNT_WIDTH = IDX_WIDTH + 1;
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(NUM_CLASSES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  state_e                state_q,     state_d;
  logic [CNT_WIDTH-1:0]  cnt_q,       cnt_d;
  logic [DATA_WIDTH-1:0] max_q,       max_d;
  logic [IDX_WIDTH-1:0]  idx_q,       idx_d;
  logic                  in_ready_q,  in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic                  len_err_q,   len_err_d;
  logic                  intr_q,      intr_d;

  logic                  beat_fire;
  logic                  beat_is_last;
  logic                  score_gt;

  mlp_signed_max_cmp #(
    .WIDTH (DATA_WIDTH)
  ) u_cmp (
    .a  (in_data),
    .b  (max_q),
    .gt (score_gt)
  );

  always_comb begin
    beat_fire    = in_valid && in_ready_q;
    beat_is_last = (cnt_q == CNT_LAST);

    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    idx_d     = idx_q;
    len_err_d = len_err_q;
    intr_d    = intr_q;

    if (soft_clear) begin
      // Abort wins over everything; a beat offered this cycle is dropped.
      // The last result registers are intentionally left untouched.
      state_d   = ST_IDLE;
      cnt_d     = '0;
      len_err_d = 1'b0;
      intr_d    = 1'b0;
    end else begin
      if (intr_clr) begin
        intr_d = 1'b0;
      end

      case (state_q)
        ST_IDLE, ST_SCAN: begin
          if (beat_fire) begin
            if (state_q == ST_IDLE) begin
              // First beat seeds the running maximum unconditionally.
              max_d = in_data;
              idx_d = '0;
            end else if (score_gt) begin
              max_d = in_data;
              idx_d = cnt_q[IDX_WIDTH-1:0];
            end

            // in_last is only a consistency check; sequencing is by count.
            if (in_last != beat_is_last) begin
              len_err_d = 1'b1;
            end

            if (beat_is_last) begin
              state_d = ST_DONE;
              cnt_d   = '0;
              // Completion set overrides a same-cycle intr_clr.
              intr_d  = 1'b1;
            end else begin
              state_d = ST_SCAN;
              cnt_d   = cnt_q + CNT_ONE;
            end
          end
        end

        ST_DONE: begin
          if (out_ready) begin
            state_d = ST_IDLE;
          end
        end

        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    // Handshake flags are registered from the next state so they line up
    // with the state they describe; both read 0 while reset is held.
    in_ready_d  = (state_d != ST_DONE);
    out_valid_d = (state_d == ST_DONE);
  end

  always_ff @(posedge s_axi_aclk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      idx_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      len_err_q   <= 1'b0;
      intr_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      len_err_q   <= len_err_d;
      intr_q      <= intr_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_idx   = idx_q;
  assign out_max   = max_q;
  assign out_valid = out_valid_q;
  assign len_err   = len_err_q;
  assign intr      = intr_q;

endmodule : mlp_argmax
`default_nettype wire

// File: tb/tb_mlp_argmax.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mlp_argmax
// Description : Self-checking bench for mlp_argmax. A transaction-level model
//               collects each inference's scores and computes the expected
//               winner from the whole array once the stream completes; a
//               compare process checks every cycle on the falling edge.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mlp_argmax;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          soft_clear = 1'b0;
  logic [DW-1:0] in_data    = '0;
  logic          in_valid   = 1'b0;
  logic          in_last    = 1'b0;
  logic          out_ready  = 1'b0;
  logic          intr_clr   = 1'b0;
  logic          in_ready;
  logic [IW-1:0] out_idx;
  logic [DW-1:0] out_max;
  logic          out_valid;
  logic          len_err;
  logic          intr;

  always #5 clk = ~clk;

  mlp_argmax #(
    .DATA_WIDTH  (DW),
    .NUM_CLASSES (N),
    .IDX_WIDTH   (IW)
  ) dut (
    .s_axi_aclk (clk),
    .reset      (rst),
    .soft_clear (soft_clear),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_idx    (out_idx),
    .out_max    (out_max),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .len_err    (len_err),
    .intr       (intr),
    .intr_clr   (intr_clr)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Winner = first index holding the largest signed value of the full array.
  function automatic int ref_argmax(input logic [DW-1:0] s[N], input logic [DW-1:0] lastv);
    logic [DW-1:0] a[N];
    int best;
    a = s;
    a[N-1] = lastv;
    best = 0;
    for (int i = 1; i < N; i++)
      if ($signed(a[i]) > $signed(a[best])) best = i;
    return best;
  endfunction

  function automatic logic [DW-1:0] ref_maxval(input logic [DW-1:0] s[N], input logic [DW-1:0] lastv);
    logic [DW-1:0] a[N];
    a = s;
    a[N-1] = lastv;
    return a[ref_argmax(s, lastv)];
  endfunction

  int            m_cnt;
  logic [DW-1:0] m_sc[N];
  logic          m_valid, m_intr, m_lerr, m_rdy;
  logic [IW-1:0] m_idx;
  logic [DW-1:0] m_max;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_cnt <= 0; m_valid <= 1'b0; m_intr <= 1'b0; m_lerr <= 1'b0;
      m_rdy <= 1'b0; m_idx <= '0; m_max <= '0;
    end else if (soft_clear) begin
      m_cnt <= 0; m_valid <= 1'b0; m_intr <= 1'b0; m_lerr <= 1'b0; m_rdy <= 1'b1;
    end else begin
      if (intr_clr) m_intr <= 1'b0;
      if (m_valid) begin
        if (out_ready) begin
          m_valid <= 1'b0;
          m_rdy   <= 1'b1;
        end
      end else begin
        m_rdy <= 1'b1;
        if (in_valid && m_rdy) begin
          m_sc[m_cnt] <= in_data;
          if (in_last != (m_cnt == N-1)) m_lerr <= 1'b1;
          if (m_cnt == N-1) begin
            m_idx   <= IW'(ref_argmax(m_sc, in_data));
            m_max   <= ref_maxval(m_sc, in_data);
            m_valid <= 1'b1;
            m_intr  <= 1'b1;
            m_rdy   <= 1'b0;
            m_cnt   <= 0;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready", in_ready, m_rdy);
      chk("out_valid", out_valid, m_valid);
      chk("intr", intr, m_intr);
      chk("len_err", len_err, m_lerr);
      if (m_valid || rst) begin
        chk("out_idx", out_idx, m_idx);
        chk("out_max", out_max, m_max);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [DW-1:0] d, input logic l, input logic clr);
    int   budget;
    logic acc;
    budget = 0;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d; in_last = l; intr_clr = clr;
    while (!acc && budget < 200) begin
      acc = in_ready;
      @(negedge clk);
      budget++;
    end
    if (!acc) begin
      n_checks++;
      $display("FAIL send_timeout: in_ready got 0 expected 1 at %0t", $time);
    end
    intr_clr = 1'b0;
  endtask

  task automatic stream(input logic [DW-1:0] s[N], input int last_pos, input int gap_max,
                        input logic clr_last);
    for (int i = 0; i < N; i++) begin
      send(s[i], (i == last_pos), clr_last && (i == N-1));
      if (gap_max > 0 && i != N-1 && ($urandom % 3) == 0) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, gap_max)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic accept(input int delay);
    int b;
    b = 0;
    while (!out_valid && b < 100) begin
      @(negedge clk);
      b++;
    end
    if (!out_valid) begin
      n_checks++;
      $display("FAIL accept_timeout: out_valid got 0 expected 1 at %0t", $time);
    end
    repeat (delay) @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    intr_clr = 1'b1;
    @(negedge clk);
    intr_clr = 1'b0;
  endtask

  function automatic logic [DW-1:0] rnd_score();
    case ($urandom_range(0, 2))
      0:       return DW'($urandom);
      1:       return DW'(int'($urandom_range(0, 6)) - 3);
      default: return ($urandom % 2) ? 16'h7FFF : 16'h8000;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  logic [DW-1:0] s[N];
  int            v[N];

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_max", out_max, 0);
    chk("rst_intr", intr, 0);
    rst = 1'b0;

    // Mixed scores with a tie at index 4 that must lose to index 2.
    v = '{3, -5, 7, 2, 7, 1, 0, -1, 6, 4};
    for (int i = 0; i < N; i++) s[i] = DW'(v[i]);
    stream(s, N-1, 0, 1'b0);
    chk("t1_valid", out_valid, 1);
    chk("t1_idx", out_idx, 2);
    chk("t1_max", out_max, 7);
    chk("t1_model_idx", m_idx, 2);
    chk("t1_intr", intr, 1);
    chk("t1_len_err", len_err, 0);
    accept(2);
    pulse_clr();

    // All scores at the most negative value: index 0 wins.
    for (int i = 0; i < N; i++) s[i] = 16'h8000;
    stream(s, N-1, 0, 1'b0);
    chk("t2_idx", out_idx, 0);
    chk("t2_max", out_max, 16'h8000);
    accept(0);

    // Largest positive at the final index.
    s[N-1] = 16'h7FFF;
    stream(s, N-1, 0, 1'b0);
    chk("t3_idx", out_idx, 9);
    chk("t3_max", out_max, 16'h7FFF);
    chk("t3_model_max", m_max, 16'h7FFF);

    // Back-pressure: result held, no beat consumed while out_ready stays low.
    in_valid = 1'b1; in_data = 16'h1234; in_last = 1'b0;
    repeat (20) @(negedge clk);
    chk("t4_in_ready", in_ready, 0);
    chk("t4_idx_hold", out_idx, 9);
    in_valid = 1'b0;
    accept(0);
    chk("t4_ready_back", in_ready, 1);

    // Early in_last on beat 5 and missing on beat 9.
    for (int i = 0; i < N; i++) s[i] = DW'(v[i]);
    for (int i = 0; i < N; i++) begin
      send(s[i], (i == 5), 1'b0);
      if (i == 5) chk("t5_len_err_early", len_err, 1);
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("t5_valid", out_valid, 1);
    chk("t5_idx", out_idx, 2);
    soft_clear = 1'b1;
    @(negedge clk);
    soft_clear = 1'b0;
    chk("t5_len_err_clr", len_err, 0);
    chk("t5_intr_clr", intr, 0);
    chk("t5_idx_kept", out_idx, 2);

    // Asynchronous reset mid-scan with large partial scores.
    for (int i = 0; i < 5; i++) send(16'd1000, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk("t6_rst_ready", in_ready, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    v = '{1, 2, 3, 4, 5, 6, 7, 8, 100, 9};
    for (int i = 0; i < N; i++) s[i] = DW'(v[i]);
    stream(s, N-1, 0, 1'b0);
    chk("t6_idx", out_idx, 8);
    chk("t6_max", out_max, 100);
    accept(1);

    // intr_clr coinciding with completion: set wins.
    pulse_clr();
    chk("t7_intr_low", intr, 0);
    stream(s, N-1, 0, 1'b1);
    chk("t7_intr_set_wins", intr, 1);
    accept(0);
    chk("t7_intr_after_accept", intr, 1);
    pulse_clr();
    chk("t7_intr_cleared", intr, 0);

    // Randomized inferences with gaps, ties, back-pressure and aborts.
    for (int it = 0; it < 30; it++) begin
      if (it % 7 == 3) begin
        for (int i = 0; i < 3; i++) send(rnd_score(), 1'b0, 1'b0);
        in_valid = 1'b1;
        soft_clear = 1'b1;
        @(negedge clk);
        soft_clear = 1'b0;
        in_valid = 1'b0;
      end
      for (int i = 0; i < N; i++) s[i] = rnd_score();
      stream(s, (it % 5 == 4) ? int'($urandom_range(0, N-1)) : N-1, 3,
             1'b0);
      accept($urandom_range(0, 4));
      if ($urandom % 2) pulse_clr();
    end

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mlp_argmax
`default_nettype wire
